// File: rtl/calc_pkg.sv
// Shared types and helpers for the calculator operand-entry path.
package calc_pkg;

  localparam int unsigned BCD_W = 4;

  typedef enum logic [1:0] {
    ENTRY,
    CONVERT,
    DONE
  } entry_state_t;

  function automatic logic is_bcd_digit(input logic [BCD_W-1:0] d);
    return d <= BCD_W'(9);
  endfunction

endpackage

// File: rtl/decimal_entry_bcd_unadjust.sv
// One nibble of the reverse double-dabble correction: nibbles >= 8 lose 3.
module bcd_unadjust
  import calc_pkg::*;
(
  input  logic [BCD_W-1:0] nib_i,
  output logic [BCD_W-1:0] nib_o
);

  always_comb begin
    nib_o = (nib_i >= BCD_W'(8)) ? nib_i - BCD_W'(3) : nib_i;
  end

endmodule

// File: rtl/decimal_entry.sv
// Keyed decimal entry buffer (packed BCD) with sequential BCD->binary conversion.
// Optional backspace key: define DECIMAL_ENTRY_BACKSPACE_EN.
module decimal_entry
  import calc_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 6,
  parameter int unsigned NUM_WIDTH  = 21
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 digit_valid,
  input  logic [BCD_W-1:0]                     digit,
`ifdef DECIMAL_ENTRY_BACKSPACE_EN
  input  logic                                 backspace,
`endif
  input  logic                                 clear,
  input  logic                                 commit,
  output logic [BCD_W*NUM_DIGITS-1:0]          bcds,
  output logic [$clog2(NUM_DIGITS+1)-1:0]      digit_count,
  output logic                                 overflow,
  output logic                                 busy,
  output logic [NUM_WIDTH-1:0]                 num,
  output logic                                 num_valid
);

  localparam int unsigned BW = BCD_W * NUM_DIGITS;
  localparam int unsigned CW = $clog2(NUM_DIGITS + 1);
  localparam int unsigned IW = $clog2(BW + 1);

  entry_state_t         state_q, state_d;
  logic [BW-1:0]        bcds_q, bcds_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 ovf_q, ovf_d;
  logic [BW-1:0]        work_q, work_d;
  logic [NUM_WIDTH-1:0] bin_q, bin_d;
  logic [IW-1:0]        iter_q, iter_d;
  logic [NUM_WIDTH-1:0] num_q, num_d;
  logic                 nv_q, nv_d;

  logic [BW-1:0]        work_sh;
  logic [BW-1:0]        work_adj;

  assign work_sh = work_q >> 1;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_unadj
    bcd_unadjust u_unadj (
      .nib_i (work_sh[g*BCD_W +: BCD_W]),
      .nib_o (work_adj[g*BCD_W +: BCD_W])
    );
  end

  always_comb begin
    state_d = state_q;
    bcds_d  = bcds_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    work_d  = work_q;
    bin_d   = bin_q;
    iter_d  = iter_q;
    num_d   = num_q;
    nv_d    = 1'b0;
    unique case (state_q)
      ENTRY: begin
        if (clear) begin
          bcds_d  = '0;
          count_d = '0;
          ovf_d   = 1'b0;
        end else if (commit) begin
          work_d  = bcds_q;
          bin_d   = '0;
          iter_d  = '0;
          state_d = CONVERT;
        end
`ifdef DECIMAL_ENTRY_BACKSPACE_EN
        else if (backspace) begin
          if (count_q != '0) begin
            bcds_d  = bcds_q >> BCD_W;
            count_d = count_q - CW'(1);
            ovf_d   = 1'b0;
          end
        end
`endif
        else if (digit_valid && is_bcd_digit(digit)) begin
          if (count_q == CW'(NUM_DIGITS)) begin
            ovf_d = 1'b1;
          end else begin
            bcds_d  = {bcds_q[BW-BCD_W-1:0], digit};
            count_d = count_q + CW'(1);
          end
        end
      end
      CONVERT: begin
        if (clear) begin
          bcds_d  = '0;
          count_d = '0;
          ovf_d   = 1'b0;
          state_d = ENTRY;
        end else begin
          work_d = work_adj;
          // Only the first NUM_WIDTH shifted-out bits can be nonzero, so bin
          // shifts for those iterations and then holds, already LSB-aligned.
          if (iter_q < IW'(NUM_WIDTH)) begin
            bin_d = {work_q[0], bin_q[NUM_WIDTH-1:1]};
          end
          iter_d = iter_q + IW'(1);
          if (iter_q == IW'(BW - 1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        num_d   = bin_q;
        nv_d    = 1'b1;
        bcds_d  = '0;
        count_d = '0;
        ovf_d   = 1'b0;
        state_d = ENTRY;
      end
      default: state_d = ENTRY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ENTRY;
      bcds_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      work_q  <= '0;
      bin_q   <= '0;
      iter_q  <= '0;
      num_q   <= '0;
      nv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      bcds_q  <= bcds_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      work_q  <= work_d;
      bin_q   <= bin_d;
      iter_q  <= iter_d;
      num_q   <= num_d;
      nv_q    <= nv_d;
    end
  end

  assign bcds        = bcds_q;
  assign digit_count = count_q;
  assign overflow    = ovf_q;
  assign busy        = (state_q == CONVERT);
  assign num         = num_q;
  assign num_valid   = nv_q;

endmodule

// File: tb/tb_decimal_entry.sv
// Scoreboard bench for decimal_entry: stimulus pushes expected conversions, monitor checks them.
module tb_decimal_entry;

  logic        clk = 1'b0;
  logic        reset;
  logic        digit_valid;
  logic [3:0]  digit;
  logic        backspace;
  logic        clear;
  logic        commit;
  logic [23:0] bcds;
  logic [2:0]  digit_count;
  logic        overflow;
  logic        busy;
  logic [20:0] num;
  logic        num_valid;

  typedef struct {
    logic [20:0] num;
    int          at;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  decimal_entry #(.NUM_DIGITS(6), .NUM_WIDTH(21)) dut (
    .clk         (clk),
    .reset       (reset),
    .digit_valid (digit_valid),
    .digit       (digit),
`ifdef DECIMAL_ENTRY_BACKSPACE_EN
    .backspace   (backspace),
`endif
    .clear       (clear),
    .commit      (commit),
    .bcds        (bcds),
    .digit_count (digit_count),
    .overflow    (overflow),
    .busy        (busy),
    .num         (num),
    .num_valid   (num_valid)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every num_valid pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (!reset && num_valid === 1'b1) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_num_valid: got num 0x%0h expected no pulse", num);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("num", 32'(num), 32'(e.num));
        check("num_latency_edge", 32'(cyc), 32'(e.at));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic key(input logic [3:0] d);
    digit_valid = 1'b1;
    digit       = d;
    tick();
    digit_valid = 1'b0;
    digit       = '0;
  endtask

  task automatic do_commit(input logic [20:0] exp_num);
    exp_t e;
    int   bc;
    e.num = exp_num;
    e.at  = cyc + 1 + 25;
    q.push_back(e);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    bc = 0;
    while (busy === 1'b1 && bc < 60) begin
      bc++;
      tick();
    end
    check("busy_cycles", 32'(bc), 32'd24);
    tick();
    tick();
    check("bcds_after_done", 32'(bcds), 32'h0);
    check("count_after_done", 32'(digit_count), 32'd0);
    check("ovf_after_done", 32'(overflow), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; digit_valid = 1'b0; digit = '0;
    backspace = 1'b0; clear = 1'b0; commit = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst_bcds", 32'(bcds), 32'h0);
    check("rst_count", 32'(digit_count), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_num", 32'(num), 32'd0);
    check("rst_num_valid", 32'(num_valid), 32'd0);

    // Empty entry converts to zero.
    do_commit(21'd0);

    // 123456
    for (int i = 1; i <= 6; i++) key(4'(i));
    check("bcds_123456", 32'(bcds), 32'h123456);
    check("count_6", 32'(digit_count), 32'd6);
    do_commit(21'h1E240);

    // Full buffer of 9s plus a rejected 7th key.
    for (int i = 0; i < 7; i++) key(4'd9);
    check("bcds_999999", 32'(bcds), 32'h999999);
    check("count_full", 32'(digit_count), 32'd6);
    check("ovf_set", 32'(overflow), 32'd1);
    do_commit(21'hF423F);

    // Non-BCD digit ignored without flag.
    key(4'd3);
    key(4'hA);
    check("bcds_after_A", 32'(bcds), 32'h3);
    check("count_after_A", 32'(digit_count), 32'd1);
    check("ovf_after_A", 32'(overflow), 32'd0);

    // Clear beats commit in the same cycle.
    clear = 1'b1; tick(); clear = 1'b0;
    key(4'd4);
    key(4'd2);
    check("bcds_42", 32'(bcds), 32'h42);
    clear = 1'b1; commit = 1'b1;
    tick();
    clear = 1'b0; commit = 1'b0;
    check("clrcommit_bcds", 32'(bcds), 32'h0);
    check("clrcommit_count", 32'(digit_count), 32'd0);
    check("clrcommit_busy", 32'(busy), 32'd0);
    repeat (30) tick();

    // Abort a conversion on its 10th cycle.
    key(4'd7);
    key(4'd0);
    commit = 1'b1; tick(); commit = 1'b0;
    check("abort_busy_start", 32'(busy), 32'd1);
    repeat (9) tick();
    check("abort_busy_before", 32'(busy), 32'd1);
    clear = 1'b1; tick(); clear = 1'b0;
    check("abort_busy_drop", 32'(busy), 32'd0);
    repeat (30) tick();
    check("abort_num_kept", 32'(num), 32'hF423F);
    check("abort_bcds", 32'(bcds), 32'h0);
    check("abort_count", 32'(digit_count), 32'd0);

`ifdef DECIMAL_ENTRY_BACKSPACE_EN
    backspace = 1'b1; tick(); backspace = 1'b0;
    check("bksp_empty_bcds", 32'(bcds), 32'h0);
    check("bksp_empty_count", 32'(digit_count), 32'd0);
    key(4'd5);
    key(4'd6);
    key(4'd7);
    backspace = 1'b1; tick(); backspace = 1'b0;
    check("bksp_bcds", 32'(bcds), 32'h56);
    check("bksp_count", 32'(digit_count), 32'd2);
    do_commit(21'd56);
`endif

    repeat (5) tick();
    check("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
